bfu_dif: RTL and testbench
==========================

Name: bfu_dif

Overview:
Radix-2 decimation-in-frequency butterfly, the counterpart of the existing decimation-in-time BFU. Computes out_a = a + b and out_b = (a − b)·W.
With `inverse` set, it uses conj(W) and optional 1/2 scaling, giving the IFFT / inverse-transform stage.
Streaming 3-stage pipeline with valid/ready handshake. It sits between stage reorder buffers in the FFT/IFFT datapath.

Parameters:
DW, 32, signed width of each complex component (Q16.16 fixed point)
TW, 16, signed width of each twiddle component (Q1.15)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  reset: one clock; reset is asynchronous and active-low
in_valid  input  1  input sample pair valid
in_ready  output  1  block accepts input this cycle
in_a  input  2*DW  complex a, {re[63:32], im[31:0]}
in_b  input  2*DW  complex b, same packing
twiddle  input  2*TW  W, {re[31:16], im[15:0]}, Q1.15
inverse  input  1  1: use conj(W); sampled with in_valid
scale  input  1  1: halve a±b before multiply; sampled with in_valid
out_valid  output  1  output pair valid
out_ready  input  1  downstream accepts output
out_a  output  2*DW  a+b (scaled if requested)
out_b  output  2*DW  (a−b)·W, truncated to Q16.16
ovf  output  1  sticky overflow flag
clr_ovf  input  1  synchronous clear of ovf

Behaviour:
- Reset (async assert, sync release): all stage valids 0, out_valid=0, out_a=out_b=0, ovf=0, all pipeline data registers 0. Reset mid-stream discards in-flight samples.
- Handshake: en = !out_valid | out_ready; in_ready = en (combinational).
  - Transfer in when in_valid & in_ready. Transfer out when out_valid & out_ready.
  - When en=0, the whole pipeline holds (global stall). Bubbles are not collapsed.
  - out_a, out_b and out_valid remain stable while stalled.
- Twiddle expansion to Q16.16: component 16'h7fff → exactly +1.0 (32'h0001_0000); otherwise sign-extend and shift left 1.
  - inverse=1: negate the expanded imaginary part. Negating 16'h8000 gives exactly +1.0, with no wrap.
- S1 (on accept):
  - 33-bit sum = a+b and diff = a−b per component.
  - scale=1: arithmetic shift right by 1, then truncate to DW. Cannot overflow.
  - scale=0: wrap to DW; set ovf if the 33-bit value does not fit in DW.
  - Register the expanded twiddle and valid.
- S2: four 64-bit signed products dr·wr, di·wi, dr·wi, di·wr; delay sum alongside.
- S3:
  - re = (dr·wr − di·wi) >>> 16, im = (dr·wi + di·wr) >>> 16, computed in 65 bits.
  - Arithmetic truncation (toward −∞), then wrap to DW; set ovf if the result does not fit.
  - Register out_a = delayed sum, out_b, out_valid.
- Latency: exactly 3 clk edges from accept to out_valid when never stalled. Throughput 1 pair/cycle.
- ovf: set wins over a simultaneous clr_ovf. It is only set by valid (non-bubble) stages.
- Mode bits travel with their sample; changing inverse/scale between samples affects only later samples.

Decomposition:
- Shared package fft_pkg: DW, TW, FRAC=16, ONE_Q16=32'h0001_0000, TW_ONE=16'h7fff, and a complex-pair packing typedef/field offsets reused by the BFU and the reorder buffers.
- One sub-module, bfu_dif_cmul: registered 4-product multiply (S2) plus combine/truncate/overflow detect (S3), with an enable input. Twiddle expansion stays in bfu_dif.

Test Plan:
1. inverse=0, scale=0, a=(1.0,0), b=(0.5,0), W={7fff,0000}, out_ready=1 → after 3 cycles out_a={0001_8000,0000_0000}, out_b={0000_8000,0000_0000}, ovf=0.
2. a=(1.0,0), b=0, W={0000,8000} (−j):
   - inverse=0 → out_b={0000_0000,FFFF_0000}.
   - Same sample with inverse=1 → out_b={0000_0000,0001_0000}.
3. scale=1, a=(2.0,−2.0), b=(2.0,2.0), W=1 → out_a={0002_0000,0000_0000}, out_b={0000_0000,FFFE_0000}, ovf=0.
4. scale=0, a.re=7FFF_0000, b.re=0001_0000 → out_a.re=8000_0000, ovf=1 and stays set.
   - Pulse clr_ovf → 0.
   - clr_ovf coincident with a new overflow → ovf stays 1.
5. Stream 8 distinct pairs back-to-back; hold out_ready=0 for 4 cycles mid-stream → in_ready=0 whenever out_valid&!out_ready, outputs held stable, all 8 results delivered in order, no loss or duplication.
6. Assert rst_n low with 2 samples in flight → out_valid=0 and out_a=out_b=0 immediately (async), ovf=0. After release, the first out_valid occurs 3 cycles after the first new accept.

Source files
------------

// File: rtl/fft_pkg.sv
// Shared FFT datapath definitions: sample/twiddle widths, fixed-point
// constants and the complex-pair packing used by the butterflies and the
// stage reorder buffers.
//   DW      : width of one complex component (Q16.16)
//   TW      : width of one twiddle component (Q1.15)
//   cplx_t  : {re, im} data pair, re in the upper half
//   twid_t  : {re, im} twiddle pair, re in the upper half
package fft_pkg;

    localparam int unsigned DW   = 32;
    localparam int unsigned TW   = 16;
    localparam int unsigned FRAC = 16;

    localparam logic [DW-1:0] ONE_Q16 = 32'h0001_0000;
    localparam logic [TW-1:0] TW_ONE  = 16'h7fff;

    // Field offsets of the packed pairs, for blocks that slice raw buses.
    localparam int unsigned CW        = 2 * DW;
    localparam int unsigned RE_LSB    = DW;
    localparam int unsigned IM_LSB    = 0;
    localparam int unsigned TW_RE_LSB = TW;
    localparam int unsigned TW_IM_LSB = 0;

    typedef struct packed {
        logic signed [DW-1:0] re;
        logic signed [DW-1:0] im;
    } cplx_t;

    typedef struct packed {
        logic signed [TW-1:0] re;
        logic signed [TW-1:0] im;
    } twid_t;

endpackage

// File: rtl/bfu_dif_if.sv
// Streaming port bundle of the DIF butterfly.
//   in_*     : input pair, twiddle and per-sample mode bits (valid/ready)
//   out_*    : result pair (valid/ready)
//   ovf      : sticky overflow flag, clr_ovf clears it
// slave = butterfly side, master = upstream/downstream side.
interface bfu_dif_if;
    import fft_pkg::*;

    logic  in_valid;
    logic  in_ready;
    cplx_t in_a;
    cplx_t in_b;
    twid_t twiddle;
    logic  inverse;
    logic  scale;
    logic  out_valid;
    logic  out_ready;
    cplx_t out_a;
    cplx_t out_b;
    logic  ovf;
    logic  clr_ovf;

    modport slave (
        input  in_valid, in_a, in_b, twiddle, inverse, scale, out_ready, clr_ovf,
        output in_ready, out_valid, out_a, out_b, ovf
    );

    modport master (
        output in_valid, in_a, in_b, twiddle, inverse, scale, out_ready, clr_ovf,
        input  in_ready, out_valid, out_a, out_b, ovf
    );

endinterface

// File: rtl/bfu_dif_cmul.sv
// Back half of the DIF butterfly: registered four-product complex multiply
// (S2) followed by combine, truncate-to-Q16.16 and overflow detect (S3).
//   clk, rst_n : clock, async active-low reset
//   i_en       : global pipeline advance
//   i_valid    : S1 stage valid
//   i_sum      : a+b, passed through to o_a
//   i_dif      : a-b, multiplicand
//   i_tw       : expanded Q16.16 twiddle
//   o_valid    : S3 valid
//   o_a, o_b   : a+b and (a-b)*W
//   o_ovf      : one-cycle pulse, a valid product leaving S2 does not fit DW
module bfu_dif_cmul
    import fft_pkg::*;
(
    input  logic  clk,
    input  logic  rst_n,
    input  logic  i_en,
    input  logic  i_valid,
    input  cplx_t i_sum,
    input  cplx_t i_dif,
    input  cplx_t i_tw,
    output logic  o_valid,
    output cplx_t o_a,
    output cplx_t o_b,
    output logic  o_ovf
);

    localparam int unsigned PW = 2 * DW;
    localparam int unsigned SW = PW + 1;

    function automatic logic signed [PW-1:0] smul(input logic signed [DW-1:0] x,
                                                   input logic signed [DW-1:0] y);
        logic signed [PW-1:0] xe;
        logic signed [PW-1:0] ye;
        xe = {{DW{x[DW-1]}}, x};
        ye = {{DW{y[DW-1]}}, y};
        return xe * ye;
    endfunction

    // Value fits DW when every bit from DW-1 upward is a sign copy.
    function automatic logic fits_dw(input logic [SW-1:0] x);
        logic [SW-DW:0] top;
        top = x[SW-1:DW-1];
        return (&top) | ~(|top);
    endfunction

    logic                 r_s2_valid;
    cplx_t                r_s2_sum;
    logic signed [PW-1:0] r_p_rr;
    logic signed [PW-1:0] r_p_ii;
    logic signed [PW-1:0] r_p_ri;
    logic signed [PW-1:0] r_p_ir;

    logic                 r_valid;
    cplx_t                r_a;
    cplx_t                r_b;

    logic signed [SW-1:0] w_re_full;
    logic signed [SW-1:0] w_im_full;
    logic signed [SW-1:0] w_re_sh;
    logic signed [SW-1:0] w_im_sh;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s2_valid <= 1'b0;
            r_s2_sum   <= '0;
            r_p_rr     <= '0;
            r_p_ii     <= '0;
            r_p_ri     <= '0;
            r_p_ir     <= '0;
        end else if (i_en) begin
            r_s2_valid <= i_valid;
            r_s2_sum   <= i_sum;
            r_p_rr     <= smul(i_dif.re, i_tw.re);
            r_p_ii     <= smul(i_dif.im, i_tw.im);
            r_p_ri     <= smul(i_dif.re, i_tw.im);
            r_p_ir     <= smul(i_dif.im, i_tw.re);
        end
    end

    // One extra bit keeps the combine exact; >>> floors toward -inf.
    assign w_re_full = {r_p_rr[PW-1], r_p_rr} - {r_p_ii[PW-1], r_p_ii};
    assign w_im_full = {r_p_ri[PW-1], r_p_ri} + {r_p_ir[PW-1], r_p_ir};
    assign w_re_sh   = w_re_full >>> FRAC;
    assign w_im_sh   = w_im_full >>> FRAC;

    assign o_ovf = i_en & r_s2_valid & ~(fits_dw(w_re_sh) & fits_dw(w_im_sh));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_a     <= '0;
            r_b     <= '0;
        end else if (i_en) begin
            r_valid <= r_s2_valid;
            r_a     <= r_s2_sum;
            r_b     <= {w_re_sh[DW-1:0], w_im_sh[DW-1:0]};
        end
    end

    assign o_valid = r_valid;
    assign o_a     = r_a;
    assign o_b     = r_b;

endmodule

// File: rtl/bfu_dif.sv
// Radix-2 decimation-in-frequency butterfly: out_a = a+b, out_b = (a-b)*W,
// with conj(W) and optional 1/2 pre-scaling for the inverse transform.
// Three-stage pipeline under a global stall.
//   clk, rst_n : clock, async active-low reset
//   bus        : bfu_dif_if slave (input pair, twiddle, modes, outputs, ovf)
module bfu_dif
    import fft_pkg::*;
(
    input logic      clk,
    input logic      rst_n,
    bfu_dif_if.slave bus
);

    // Q1.15 -> Q16.16 alignment shift.
    localparam int unsigned TW_SHIFT = FRAC - (TW - 1);

    // 0x7fff is promoted to exactly +1.0 so unit twiddles are lossless.
    function automatic logic signed [DW-1:0] tw_expand(input logic [TW-1:0] c);
        logic signed [DW-1:0] ext;
        ext = {{(DW - TW){c[TW-1]}}, c};
        if (c == TW_ONE) begin
            return ONE_Q16;
        end
        return ext <<< TW_SHIFT;
    endfunction

    function automatic logic [DW-1:0] fold(input logic [DW:0] x, input logic scl);
        return scl ? x[DW:1] : x[DW-1:0];
    endfunction

    logic               w_en;
    logic               w_accept;
    logic signed [DW:0] w_sum_re;
    logic signed [DW:0] w_sum_im;
    logic signed [DW:0] w_dif_re;
    logic signed [DW:0] w_dif_im;
    logic               w_s1_fit;
    logic               w_s1_ovf;
    logic               w_s3_ovf;
    logic signed [DW-1:0] w_tw_im_raw;
    cplx_t              w_sum;
    cplx_t              w_dif;
    cplx_t              w_tw;

    logic               r_s1_valid;
    cplx_t              r_s1_sum;
    cplx_t              r_s1_dif;
    cplx_t              r_s1_tw;
    logic               r_ovf;

    assign w_en         = ~bus.out_valid | bus.out_ready;
    assign w_accept     = bus.in_valid & w_en;
    assign bus.in_ready = w_en;
    assign bus.ovf      = r_ovf;

    assign w_sum_re = {bus.in_a.re[DW-1], bus.in_a.re} + {bus.in_b.re[DW-1], bus.in_b.re};
    assign w_sum_im = {bus.in_a.im[DW-1], bus.in_a.im} + {bus.in_b.im[DW-1], bus.in_b.im};
    assign w_dif_re = {bus.in_a.re[DW-1], bus.in_a.re} - {bus.in_b.re[DW-1], bus.in_b.re};
    assign w_dif_im = {bus.in_a.im[DW-1], bus.in_a.im} - {bus.in_b.im[DW-1], bus.in_b.im};

    assign w_s1_fit = (w_sum_re[DW] == w_sum_re[DW-1]) & (w_sum_im[DW] == w_sum_im[DW-1])
                    & (w_dif_re[DW] == w_dif_re[DW-1]) & (w_dif_im[DW] == w_dif_im[DW-1]);
    // Halving a 33-bit value always fits, so only the unscaled path can overflow.
    assign w_s1_ovf = ~bus.scale & ~w_s1_fit;

    assign w_tw_im_raw = tw_expand(bus.twiddle.im);

    always_comb begin
        w_sum.re = fold(w_sum_re, bus.scale);
        w_sum.im = fold(w_sum_im, bus.scale);
        w_dif.re = fold(w_dif_re, bus.scale);
        w_dif.im = fold(w_dif_im, bus.scale);
        w_tw.re  = tw_expand(bus.twiddle.re);
        // Expanded magnitude is at most 1.0, so negation cannot wrap.
        w_tw.im  = bus.inverse ? -w_tw_im_raw : w_tw_im_raw;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_sum   <= '0;
            r_s1_dif   <= '0;
            r_s1_tw    <= '0;
        end else if (w_en) begin
            r_s1_valid <= bus.in_valid;
            r_s1_sum   <= w_sum;
            r_s1_dif   <= w_dif;
            r_s1_tw    <= w_tw;
        end
    end

    // Set has priority over clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ovf <= 1'b0;
        end else if ((w_accept & w_s1_ovf) | w_s3_ovf) begin
            r_ovf <= 1'b1;
        end else if (bus.clr_ovf) begin
            r_ovf <= 1'b0;
        end
    end

    bfu_dif_cmul u_cmul (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_en    (w_en),
        .i_valid (r_s1_valid),
        .i_sum   (r_s1_sum),
        .i_dif   (r_s1_dif),
        .i_tw    (r_s1_tw),
        .o_valid (bus.out_valid),
        .o_a     (bus.out_a),
        .o_b     (bus.out_b),
        .o_ovf   (w_s3_ovf)
    );

endmodule

// File: tb/tb_bfu_dif.sv
// Self-checking bench for bfu_dif: directed vector table, overflow and reset
// sequences, and a randomized stall-heavy stream against an arithmetic model.
module tb_bfu_dif;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    bfu_dif_if bus ();

    bfu_dif dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [63:0] a;
        logic [63:0] b;
        logic [31:0] w;
        logic        inv;
        logic        scl;
        logic [63:0] ea;
        logic [63:0] eb;
    } vec_t;

    typedef struct {
        logic [63:0] a;
        logic [63:0] b;
    } res_t;

    vec_t vecs[8];
    res_t expq[$];

    localparam longint MAXV = 64'sd2147483647;
    localparam longint MINV = -MAXV - 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    // Reference model: plain integer arithmetic on the butterfly equations.
    function automatic longint texp(input logic [15:0] c);
        if (c == 16'h7fff) return 65536;
        return longint'($signed(c)) * 2;
    endfunction

    function automatic longint wrap32(input longint x);
        logic [31:0] t;
        t = x[31:0];
        return longint'($signed(t));
    endfunction

    function automatic bit fits32(input longint x);
        return (x >= MINV) && (x <= MAXV);
    endfunction

    function automatic void model(input logic [63:0] a, input logic [63:0] b,
                                  input logic [31:0] w, input logic inv, input logic scl,
                                  output logic [63:0] oa, output logic [63:0] ob,
                                  output logic ov);
        longint ar, ai, br, bi, sr, si, dr, di, wr, wi, pr, pi;
        ar = longint'($signed(a[63:32]));
        ai = longint'($signed(a[31:0]));
        br = longint'($signed(b[63:32]));
        bi = longint'($signed(b[31:0]));
        sr = ar + br; si = ai + bi; dr = ar - br; di = ai - bi;
        ov = 1'b0;
        if (scl) begin
            sr = sr >>> 1; si = si >>> 1; dr = dr >>> 1; di = di >>> 1;
        end else begin
            ov = !fits32(sr) || !fits32(si) || !fits32(dr) || !fits32(di);
        end
        sr = wrap32(sr); si = wrap32(si); dr = wrap32(dr); di = wrap32(di);
        wr = texp(w[31:16]);
        wi = texp(w[15:0]);
        if (inv) wi = -wi;
        pr = (dr * wr - di * wi) >>> 16;
        pi = (dr * wi + di * wr) >>> 16;
        if (!fits32(pr) || !fits32(pi)) ov = 1'b1;
        oa = {sr[31:0], si[31:0]};
        ob = {pr[31:0], pi[31:0]};
    endfunction

    function automatic logic [31:0] rnd_comp();
        case ($urandom_range(0, 3))
            0:       return $urandom_range(0, 32'h0008_0000) - 32'h0004_0000;
            1:       return ($urandom_range(0, 1) != 0) ? 32'h7fff_0000 : 32'h8000_0000;
            default: return $urandom();
        endcase
    endfunction

    function automatic logic [15:0] rnd_tw();
        case ($urandom_range(0, 3))
            0:       return 16'h7fff;
            1:       return 16'h8000;
            default: return 16'($urandom_range(0, 16'hffff));
        endcase
    endfunction

    task automatic drive(input logic v, input logic [63:0] a, input logic [63:0] b,
                         input logic [31:0] w, input logic inv, input logic scl);
        bus.in_valid = v;
        bus.in_a     = a;
        bus.in_b     = b;
        bus.twiddle  = w;
        bus.inverse  = inv;
        bus.scale    = scl;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] ea, eb, hold_a, hold_b;
        logic        eo, exp_ovf, held;
        int          sent, got;
        localparam int NS = 40;

        vecs[0] = '{64'h0001_0000_0000_0000, 64'h0000_8000_0000_0000, 32'h7fff_0000, 0, 0,
                    64'h0001_8000_0000_0000, 64'h0000_8000_0000_0000};
        vecs[1] = '{64'h0001_0000_0000_0000, 64'h0, 32'h0000_8000, 0, 0,
                    64'h0001_0000_0000_0000, 64'h0000_0000_ffff_0000};
        vecs[2] = '{64'h0001_0000_0000_0000, 64'h0, 32'h0000_8000, 1, 0,
                    64'h0001_0000_0000_0000, 64'h0000_0000_0001_0000};
        vecs[3] = '{64'h0002_0000_fffe_0000, 64'h0002_0000_0002_0000, 32'h7fff_0000, 0, 1,
                    64'h0002_0000_0000_0000, 64'h0000_0000_fffe_0000};
        vecs[4] = '{64'h0003_0000_0001_0000, 64'h0001_0000_0000_0000, 32'h8000_0000, 0, 0,
                    64'h0004_0000_0001_0000, 64'hfffe_0000_ffff_0000};
        vecs[5] = '{64'hffff_ffff_0000_0000, 64'h0, 32'h4000_0000, 0, 0,
                    64'hffff_ffff_0000_0000, 64'hffff_ffff_0000_0000};
        vecs[6] = '{64'h0001_0000_0000_0000, 64'h0, 32'h0000_7fff, 1, 0,
                    64'h0001_0000_0000_0000, 64'h0000_0000_ffff_0000};
        vecs[7] = '{64'h0000_0003_ffff_fffd, 64'h0, 32'h7fff_0000, 0, 1,
                    64'h0000_0001_ffff_fffe, 64'h0000_0001_ffff_fffe};

        rst_n = 1'b0;
        drive(0, 64'h0, 64'h0, 32'h0, 0, 0);
        bus.out_ready = 1'b1;
        bus.clr_ovf   = 1'b0;
        #7;
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_out_a", bus.out_a, 0);
        chk("rst_out_b", bus.out_b, 0);
        chk("rst_ovf", bus.ovf, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed table, each vector alone with exact 3-edge latency.
        for (int i = 0; i < 8; i++) begin
            drive(1, vecs[i].a, vecs[i].b, vecs[i].w, vecs[i].inv, vecs[i].scl);
            @(negedge clk);
            bus.in_valid = 1'b0;
            @(negedge clk);
            chk($sformatf("vec%0d_early", i), bus.out_valid, 0);
            @(negedge clk);
            chk($sformatf("vec%0d_valid", i), bus.out_valid, 1);
            chk($sformatf("vec%0d_a", i), bus.out_a, vecs[i].ea);
            chk($sformatf("vec%0d_b", i), bus.out_b, vecs[i].eb);
            chk($sformatf("vec%0d_ovf", i), bus.ovf, 0);
            @(negedge clk);
        end

        // Bubbles carrying overflowing data must not set ovf.
        drive(0, 64'h7fff_0000_0000_0000, 64'h0001_0000_0000_0000, 32'h7fff_0000, 0, 0);
        repeat (2) @(negedge clk);
        drive(0, 64'h7fff_0000_8000_0000, 64'h0, 32'h7fff_7fff, 0, 0);
        repeat (4) @(negedge clk);
        chk("bubble_no_ovf", bus.ovf, 0);

        // Sum overflow: wraps, flag set at accept, sticky, cleared by clr_ovf.
        drive(1, 64'h7fff_0000_0000_0000, 64'h0001_0000_0000_0000, 32'h7fff_0000, 0, 0);
        @(negedge clk);
        bus.in_valid = 1'b0;
        chk("ovf_s1_set", bus.ovf, 1);
        repeat (2) @(negedge clk);
        chk("ovf_wrap_valid", bus.out_valid, 1);
        chk("ovf_wrap_a", bus.out_a, 64'h8000_0000_0000_0000);
        chk("ovf_wrap_b", bus.out_b, 64'h7ffe_0000_0000_0000);
        repeat (3) @(negedge clk);
        chk("ovf_sticky", bus.ovf, 1);
        bus.clr_ovf = 1'b1;
        @(negedge clk);
        bus.clr_ovf = 1'b0;
        chk("ovf_cleared", bus.ovf, 0);
        bus.in_valid = 1'b1;
        bus.clr_ovf  = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.clr_ovf  = 1'b0;
        chk("ovf_set_beats_clr", bus.ovf, 1);
        repeat (3) @(negedge clk);
        bus.clr_ovf = 1'b1;
        @(negedge clk);
        bus.clr_ovf = 1'b0;
        chk("ovf_cleared2", bus.ovf, 0);

        // Product overflow only: flag appears with the result, not earlier.
        drive(1, 64'h7fff_0000_8000_0000, 64'h0, 32'h7fff_7fff, 0, 0);
        @(negedge clk);
        bus.in_valid = 1'b0;
        chk("ovf_s3_e1", bus.ovf, 0);
        @(negedge clk);
        chk("ovf_s3_e2", bus.ovf, 0);
        @(negedge clk);
        chk("ovf_s3_e3", bus.ovf, 1);
        chk("ovf_s3_b", bus.out_b, 64'hffff_0000_ffff_0000);
        bus.clr_ovf = 1'b1;
        @(negedge clk);
        bus.clr_ovf = 1'b0;
        chk("ovf_pre_stream", bus.ovf, 0);

        // Randomized stream with random backpressure and a forced 4-cycle stall.
        sent = 0; got = 0; exp_ovf = 1'b0; held = 1'b0;
        hold_a = '0; hold_b = '0;
        for (int cyc = 0; cyc < 2000 && got < NS; cyc++) begin
            @(negedge clk);
            if (held) begin
                chk("stall_valid", bus.out_valid, 1);
                chk("stall_a", bus.out_a, hold_a);
                chk("stall_b", bus.out_b, hold_b);
            end
            bus.out_ready = (cyc >= 12 && cyc < 16) ? 1'b0 : ($urandom_range(0, 3) != 0);
            drive((sent < NS) && ($urandom_range(0, 4) != 0),
                  {rnd_comp(), rnd_comp()}, {rnd_comp(), rnd_comp()},
                  {rnd_tw(), rnd_tw()}, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            #1;
            chk("in_ready", bus.in_ready, !bus.out_valid || bus.out_ready);
            if (bus.out_valid && bus.out_ready) begin
                if (expq.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL stream_extra: got output %h, expected none", bus.out_a);
                end else begin
                    res_t r;
                    r = expq.pop_front();
                    chk($sformatf("stream%0d_a", got), bus.out_a, r.a);
                    chk($sformatf("stream%0d_b", got), bus.out_b, r.b);
                end
                got++;
            end
            if (bus.in_valid && bus.in_ready) begin
                model(bus.in_a, bus.in_b, bus.twiddle, bus.inverse, bus.scale, ea, eb, eo);
                expq.push_back('{ea, eb});
                exp_ovf |= eo;
                sent++;
            end
            held   = bus.out_valid && !bus.out_ready;
            hold_a = bus.out_a;
            hold_b = bus.out_b;
        end
        @(negedge clk);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        chk("stream_count", 64'(got), 64'(NS));
        chk("stream_left", 64'(expq.size()), 0);
        chk("stream_ovf", bus.ovf, exp_ovf);
        repeat (4) @(negedge clk);

        // Reset with samples in flight: outputs clear immediately, nothing emerges.
        drive(1, 64'h7fff_0000_0000_0000, 64'h0001_0000_0000_0000, 32'h7fff_0000, 0, 0);
        @(negedge clk);
        drive(1, 64'h0001_0000_0001_0000, 64'h0, 32'h7fff_0000, 0, 0);
        repeat (2) @(negedge clk);
        bus.in_valid = 1'b0;
        chk("prerst_valid", bus.out_valid, 1);
        chk("prerst_ovf", bus.ovf, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_valid", bus.out_valid, 0);
        chk("async_a", bus.out_a, 0);
        chk("async_b", bus.out_b, 0);
        chk("async_ovf", bus.ovf, 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk($sformatf("flushed%0d", k), bus.out_valid, 0);
        end
        drive(1, vecs[0].a, vecs[0].b, vecs[0].w, 0, 0);
        @(negedge clk);
        bus.in_valid = 1'b0;
        chk("postrst_e1", bus.out_valid, 0);
        @(negedge clk);
        chk("postrst_e2", bus.out_valid, 0);
        @(negedge clk);
        chk("postrst_e3", bus.out_valid, 1);
        chk("postrst_a", bus.out_a, vecs[0].ea);
        chk("postrst_b", bus.out_b, vecs[0].eb);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
